// File: rtl/data_ram256x8_if.sv
// Bus bundle for the 256x8 data RAM: request fields plus registered read data.
interface data_ram256x8_if;
    logic        Enable;     // 1 = perform the access on this edge
    logic        ReadWrite;  // 0 = read, 1 = write
    logic [31:0] Address;    // byte address, only [7:0] decoded
    logic [31:0] DataIn;     // write data, right-justified per Size
    logic [1:0]  Size;       // 00 byte, 01 halfword, 10/11 word
    logic [31:0] DataOut;    // registered read data

    // Requester side
    modport master (
        output Enable,
        output ReadWrite,
        output Address,
        output DataIn,
        output Size,
        input  DataOut
    );

    // Memory side
    modport slave (
        input  Enable,
        input  ReadWrite,
        input  Address,
        input  DataIn,
        input  Size,
        output DataOut
    );
endinterface

// File: rtl/data_ram256x8.sv
// 256 x 8 byte-addressed data RAM, big-endian, with byte/halfword/word
// accesses that wrap modulo 256. One-cycle registered read, synchronous
// active-low reset that clears only the read register, never the array.
module data_ram256x8 (
    input logic             clk,
    input logic             rst_n,
    data_ram256x8_if.slave  bus
);

    // Storage; kept under this exact name so a bench can preload it.
    logic [7:0] Mem [256];

    logic [7:0]       addr;       // decoded byte address
    logic [3:0][7:0]  lane_addr;  // lane k targets addr + k, wrapping at 256
    logic [3:0][7:0]  lane_data;  // write byte for each lane, MSB first
    logic [3:0]       lane_en;    // lanes touched by this access size
    logic [31:0]      rd_data;    // read value assembled for DataOut
    logic             rd_fire;
    logic             wr_fire;

    // Upper address bits are architecturally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.Address[31:8];

    assign addr    = bus.Address[7:0];
    assign rd_fire = rst_n & bus.Enable & ~bus.ReadWrite;
    assign wr_fire = rst_n & bus.Enable &  bus.ReadWrite;

    // Per-lane addresses; 8-bit addition gives the modulo-256 wrap for free.
    always_comb begin
        lane_addr = '0;
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = addr + 8'(k);
        end
    end

    // Size decode: pick active lanes, map right-justified DataIn onto them
    // big-endian, and assemble the zero-extended read value.
    always_comb begin
        lane_en   = 4'b0000;
        lane_data = '0;
        rd_data   = 32'h0;
        unique case (bus.Size)
            2'b00: begin
                lane_en      = 4'b0001;
                lane_data[0] = bus.DataIn[7:0];
                rd_data      = {24'h0, Mem[lane_addr[0]]};
            end
            2'b01: begin
                lane_en      = 4'b0011;
                lane_data[0] = bus.DataIn[15:8];
                lane_data[1] = bus.DataIn[7:0];
                rd_data      = {16'h0, Mem[lane_addr[0]], Mem[lane_addr[1]]};
            end
            2'b10, 2'b11: begin
                lane_en      = 4'b1111;
                lane_data[0] = bus.DataIn[31:24];
                lane_data[1] = bus.DataIn[23:16];
                lane_data[2] = bus.DataIn[15:8];
                lane_data[3] = bus.DataIn[7:0];
                rd_data      = {Mem[lane_addr[0]], Mem[lane_addr[1]],
                                Mem[lane_addr[2]], Mem[lane_addr[3]]};
            end
            default: begin
                lane_en = 4'b0000;
            end
        endcase
    end

    // Read register: cleared by reset, loaded on reads, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.DataOut <= 32'h0;
        end else if (rd_fire) begin
            bus.DataOut <= rd_data;
        end
    end

    // Array write: only addressed lanes change; reset never touches contents.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            if (lane_en[0]) Mem[lane_addr[0]] <= lane_data[0];
            if (lane_en[1]) Mem[lane_addr[1]] <= lane_data[1];
            if (lane_en[2]) Mem[lane_addr[2]] <= lane_data[2];
            if (lane_en[3]) Mem[lane_addr[3]] <= lane_data[3];
        end
    end

endmodule

// File: tb/tb_data_ram256x8.sv
// Directed bench for data_ram256x8: preload, sized reads/writes, wrap,
// hold behaviour and reset priority, all against hand-computed values.
module tb_data_ram256x8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    data_ram256x8_if bus ();

    data_ram256x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison, report it if it differs.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present one request for a single edge; called just after a negedge,
    // returns at the next negedge with Enable dropped.
    task automatic access(input logic rw, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] d);
        bus.Enable    = 1'b1;
        bus.ReadWrite = rw;
        bus.Address   = a;
        bus.Size      = sz;
        bus.DataIn    = d;
        @(negedge clk);
        bus.Enable    = 1'b0;
    endtask

    task automatic idle();
        bus.Enable = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] pre [8];

    initial begin
        n_checks = 0;
        n_fails  = 0;
        pre = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 8; i++) dut.Mem[i] = pre[i];

        rst_n         = 1'b0;
        bus.Enable    = 1'b0;
        bus.ReadWrite = 1'b0;
        bus.Address   = 32'h0;
        bus.Size      = 2'b10;
        bus.DataIn    = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("reset_dataout", bus.DataOut, 32'h0);
        rst_n = 1'b1;

        // Reads of preloaded data
        access(1'b0, 32'd0, 2'b10, 32'h0);
        check("word_rd_0", bus.DataOut, 32'h11223344);
        access(1'b0, 32'd4, 2'b10, 32'h0);
        check("word_rd_4", bus.DataOut, 32'h55667788);
        access(1'b0, 32'd0, 2'b00, 32'h0);
        check("byte_rd_0", bus.DataOut, 32'h00000011);
        access(1'b0, 32'd2, 2'b01, 32'h0);
        check("half_rd_2", bus.DataOut, 32'h00003344);
        access(1'b0, 32'hFFFF_FF03, 2'b00, 32'h0);
        check("byte_rd_hi_addr", bus.DataOut, 32'h00000044);
        access(1'b0, 32'd1, 2'b11, 32'h0);
        check("size11_rd_1", bus.DataOut, 32'h22334455);

        // DataOut holds while idle
        idle();
        idle();
        check("hold_idle", bus.DataOut, 32'h22334455);

        // Byte write with junk upper bits; DataOut holds through the write
        access(1'b1, 32'd0, 2'b00, 32'hFFFF_FFB5);
        check("hold_write", bus.DataOut, 32'h22334455);
        access(1'b0, 32'd0, 2'b10, 32'h0);
        check("byte_wr_rb", bus.DataOut, 32'hB5223344);

        // Halfword write with junk upper bits
        access(1'b1, 32'd4, 2'b01, 32'h1234_FFD3);
        access(1'b0, 32'd4, 2'b10, 32'h0);
        check("half_wr_rb", bus.DataOut, 32'hFFD37788);

        // Word write, back-to-back read
        access(1'b1, 32'd8, 2'b10, 32'hE35D8AC5);
        access(1'b0, 32'd8, 2'b10, 32'h0);
        check("word_wr_rb", bus.DataOut, 32'hE35D8AC5);
        check("mem8", {24'h0, dut.Mem[8]}, 32'h000000E3);
        check("mem11", {24'h0, dut.Mem[11]}, 32'h000000C5);

        // Enable low with a write pattern present: nothing changes
        bus.Enable    = 1'b0;
        bus.ReadWrite = 1'b1;
        bus.Address   = 32'd8;
        bus.Size      = 2'b10;
        bus.DataIn    = 32'h0;
        @(negedge clk);
        access(1'b0, 32'd8, 2'b11, 32'h0);
        check("no_wr_when_idle", bus.DataOut, 32'hE35D8AC5);

        // Wrap-around word write/read
        access(1'b1, 32'd254, 2'b10, 32'hAABBCCDD);
        check("wrap_mem254", {24'h0, dut.Mem[254]}, 32'h000000AA);
        check("wrap_mem255", {24'h0, dut.Mem[255]}, 32'h000000BB);
        check("wrap_mem0", {24'h0, dut.Mem[0]}, 32'h000000CC);
        check("wrap_mem1", {24'h0, dut.Mem[1]}, 32'h000000DD);
        access(1'b0, 32'd254, 2'b10, 32'h0);
        check("wrap_word_rd", bus.DataOut, 32'hAABBCCDD);
        access(1'b0, 32'd255, 2'b01, 32'h0);
        check("wrap_half_rd", bus.DataOut, 32'h0000BBCC);

        // Reset beats a pending read, then a pending write
        rst_n = 1'b0;
        access(1'b0, 32'd4, 2'b10, 32'h0);
        check("rst_rd_ignored", bus.DataOut, 32'h0);
        access(1'b1, 32'd2, 2'b00, 32'h0000_0000);
        check("rst_wr_ignored", {24'h0, dut.Mem[2]}, 32'h00000033);
        rst_n = 1'b1;
        access(1'b0, 32'd0, 2'b10, 32'h0);
        check("post_rst_rd_0", bus.DataOut, 32'hCCDD3344);
        access(1'b0, 32'd4, 2'b10, 32'h0);
        check("post_rst_rd_4", bus.DataOut, 32'hFFD37788);
        access(1'b0, 32'd6, 2'b01, 32'h0);
        check("post_rst_half_6", bus.DataOut, 32'h00007788);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
